// File: rtl/exponent_norm_upd.sv
// Post-add normaliser: one right shift on mantissa carry or iterative left shifts until the
// hidden bit is set, with exponent saturate/clamp and status flags for the rounding stage.
module exponent_norm_upd #(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MANT_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_WIDTH-1:0]  exp_in,
  input  logic [MANT_WIDTH+1:0] mant_in,
  input  logic                  sign_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_WIDTH-1:0]  exp_out,
  output logic [MANT_WIDTH-1:0] frac_out,
  output logic                  sign_out,
  output logic                  sticky_out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  zero
);

  localparam int unsigned MW    = MANT_WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(MANT_WIDTH + 1);

  localparam logic [EXP_WIDTH-1:0] EXP_ONE    = EXP_WIDTH'(1);
  localparam logic [EXP_WIDTH-1:0] EXP_ALL1   = {EXP_WIDTH{1'b1}};
  localparam logic [EXP_WIDTH:0]   EXP_WIDE1  = (EXP_WIDTH + 1)'(1);
  localparam logic [EXP_WIDTH:0]   EXP_SAT    = {1'b0, {EXP_WIDTH{1'b1}}};
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(MANT_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCheck, StShift, StDone} state_e;

  state_e                 state_q;
  logic [EXP_WIDTH-1:0]   exp_q;
  logic [MW-1:0]          mant_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sign_q;
  logic                   sticky_q;
  logic                   overflow_q;
  logic                   underflow_q;
  logic                   zero_q;

  // One guard bit on the increment so a carry out of the field is seen as saturation.
  logic [EXP_WIDTH:0]     exp_inc;
  logic [EXP_WIDTH-1:0]   exp_dec;

  assign exp_inc = {1'b0, exp_q} + EXP_WIDE1;
  assign exp_dec = exp_q - EXP_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      exp_q       <= '0;
      mant_q      <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      sticky_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            exp_q       <= exp_in;
            mant_q      <= mant_in;
            sign_q      <= sign_in;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
            state_q     <= StCheck;
          end
        end
        StCheck: begin
          state_q <= StDone;
          if (mant_q == '0) begin
            zero_q <= 1'b1;
            exp_q  <= '0;
            sign_q <= 1'b0;
          end else if (mant_q[MW-1]) begin
            if (exp_inc >= EXP_SAT) begin
              // Infinity: fraction and sticky are meaningless, keep flags exclusive.
              overflow_q <= 1'b1;
              exp_q      <= EXP_ALL1;
              mant_q     <= '0;
            end else begin
              mant_q   <= mant_q >> 1;
              sticky_q <= mant_q[0];
              exp_q    <= exp_inc[EXP_WIDTH-1:0];
            end
          end else if (mant_q[MW-2]) begin
            state_q <= StDone;
          end else if (exp_q <= EXP_ONE) begin
            underflow_q <= 1'b1;
            exp_q       <= '0;
          end else begin
            state_q <= StShift;
          end
        end
        StShift: begin
          mant_q <= {mant_q[MW-2:0], 1'b0};
          exp_q  <= exp_dec;
          cnt_q  <= cnt_q + CNT_ONE;
          if (mant_q[MW-3]) begin
            state_q <= StDone;
          end else if (exp_dec == EXP_ONE) begin
            underflow_q <= 1'b1;
            exp_q       <= '0;
            state_q     <= StDone;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign exp_out    = exp_q;
  assign frac_out   = mant_q[MANT_WIDTH-1:0];
  assign sign_out   = sign_q;
  assign sticky_out = sticky_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_exponent_norm_upd.sv
// Bench for exponent_norm_upd: directed vector table, randomized beats against a behavioural
// normalisation model, backpressure and mid-operation reset sequences.
module tb_exponent_norm_upd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  exp_in = '0;
  logic [24:0] mant_in = '0;
  logic        sign_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  exp_out;
  logic [22:0] frac_out;
  logic        sign_out;
  logic        sticky_out;
  logic        overflow;
  logic        underflow;
  logic        zero;

  exponent_norm_upd #(
    .EXP_WIDTH (8),
    .MANT_WIDTH(23)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_out   (exp_out),
    .frac_out  (frac_out),
    .sign_out  (sign_out),
    .sticky_out(sticky_out),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        sign;
    logic        sticky;
    logic        ovf;
    logic        unf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [7:0]  e;
    logic [24:0] m;
    logic        s;
    res_t        r;
    int          lat;
    int          hold;
  } vec_t;

  int total = 0;
  int bad = 0;

  function automatic res_t actual();
    res_t a;
    a = {exp_out, frac_out, sign_out, sticky_out, overflow, underflow, zero};
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Normalisation from the rules: find the leading one, shift until the hidden position or until
  // the exponent bottoms out at 1 (then denormal with exponent 0).
  function automatic res_t model(input logic [7:0] e, input logic [24:0] m, input logic s,
                                 output int lat);
    res_t r;
    int ei;
    int pos;
    int steps;
    logic [24:0] mm;
    r = '0;
    r.sign = s;
    lat = 2;
    ei = int'(e);
    if (m == 25'd0) begin
      r.zero = 1'b1;
      r.sign = 1'b0;
    end else if (m[24]) begin
      if (ei + 1 >= 255) begin
        r.exp = 8'hFF;
        r.ovf = 1'b1;
      end else begin
        r.exp    = 8'(ei + 1);
        r.frac   = m[23:1];
        r.sticky = m[0];
      end
    end else begin
      pos = 0;
      for (int i = 0; i < 24; i++) if (m[i]) pos = i;
      steps = 23 - pos;
      if (steps == 0) begin
        r.exp  = e;
        r.frac = m[22:0];
      end else if (ei <= 1) begin
        r.unf  = 1'b1;
        r.frac = m[22:0];
      end else begin
        if (steps > ei - 1) steps = ei - 1;
        lat = 2 + steps;
        mm = m << steps;
        r.frac = mm[22:0];
        if (mm[23]) r.exp = 8'(ei - steps);
        else r.unf = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] e, input logic [24:0] m, input logic s,
                              input logic [7:0] re, input logic [22:0] rf, input logic rs,
                              input logic st, input logic ov, input logic un, input logic z,
                              input int lat, input int hold);
    vec_t v;
    v.e = e; v.m = m; v.s = s;
    v.r = {re, rf, rs, st, ov, un, z};
    v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic run_beat(input logic [7:0] e, input logic [24:0] m, input logic s,
                          input res_t req, input int req_lat, input int hold, input string tag);
    int edges;
    @(negedge clk);
    check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    exp_in = e; mant_in = m; sign_in = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(req_lat));
    check({tag, " result"}, 64'(actual()), 64'(req));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " held result"}, 64'(actual()), 64'(req));
      check({tag, " held valid/ready"}, {62'd0, out_valid, in_ready}, 64'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " after handshake"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    vec_t vecs[$];
    res_t r;
    int   lat;
    logic [7:0]  e;
    logic [24:0] m;
    logic        s;
    int   pos;
    int   cls;
    logic seen;

    vecs.push_back(mk(8'h80, 25'h0800000, 1'b0, 8'h80, 23'h0,      1'b0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(8'h80, 25'h1800000, 1'b1, 8'h81, 23'h400000, 1'b1, 0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(8'h80, 25'h1000001, 1'b0, 8'h81, 23'h0,      1'b0, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(8'h80, 25'h0000001, 1'b0, 8'h69, 23'h0,      1'b0, 0, 0, 0, 0, 25, 0));
    vecs.push_back(mk(8'hFE, 25'h1000000, 1'b0, 8'hFF, 23'h0,      1'b0, 0, 1, 0, 0, 2, 0));
    vecs.push_back(mk(8'h03, 25'h0000100, 1'b1, 8'h00, 23'h000400, 1'b1, 0, 0, 1, 0, 4, 0));
    vecs.push_back(mk(8'h45, 25'h0000000, 1'b1, 8'h00, 23'h0,      1'b0, 0, 0, 0, 1, 2, 5));
    vecs.push_back(mk(8'h01, 25'h0400000, 1'b1, 8'h00, 23'h400000, 1'b1, 0, 0, 1, 0, 2, 0));
    vecs.push_back(mk(8'h10, 25'h0008000, 1'b0, 8'h08, 23'h0,      1'b0, 0, 0, 0, 0, 10, 0));

    // Reset state
    #2;
    check("reset valid/ready", {62'd0, out_valid, in_ready}, 64'b01);
    check("reset outputs", 64'(actual()), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_beat(vecs[i].e, vecs[i].m, vecs[i].s, vecs[i].r, vecs[i].lat,
                               vecs[i].hold, $sformatf("vec%0d", i));

    // Reset while in the left-shift loop aborts the beat
    @(negedge clk);
    exp_in = 8'h80; mant_in = 25'h0000001; sign_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset valid/ready", {62'd0, out_valid, in_ready}, 64'b01);
    check("midreset outputs", 64'(actual()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midreset no out_valid", 64'(seen), 64'd0);
    r = model(8'h20, 25'h0100000, 1'b1, lat);
    run_beat(8'h20, 25'h0100000, 1'b1, r, lat, 0, "post reset");

    for (int n = 0; n < 150; n++) begin
      cls = int'($urandom_range(0, 4));
      e = 8'($urandom);
      m = 25'($urandom);
      s = 1'($urandom);
      case (cls)
        1: begin
          pos = int'($urandom_range(0, 23));
          m = (m & ((25'd1 << pos) - 25'd1)) | (25'd1 << pos);
        end
        2: begin
          e = 8'($urandom_range(0, 6));
          m = m & 25'h00FFFFF;
        end
        3: begin
          e = 8'($urandom_range(252, 255));
          m[24] = 1'b1;
        end
        4: if ($urandom_range(0, 3) == 0) m = '0;
        default: ;
      endcase
      r = model(e, m, s, lat);
      run_beat(e, m, s, r, lat, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
